// File: rtl/button_pulse_conditioner_if.sv
// Button bundle between the raw push-button pins and the digit-entry logic.
// Levels and pulses only: there is no handshake, the consumer must sample every cycle.
interface button_pulse_conditioner_if #(
    parameter int NUM_BTN = 3
);
    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] btn_level;
    logic [NUM_BTN-1:0] btn_pulse;
    logic               conflict;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_pulse,
        input  conflict
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_pulse,
        output conflict
    );
endinterface

// File: rtl/button_pulse_conditioner.sv
// Sync + debounce raw buttons into clean one-hot press pulses; index 0 wins ties.
// Latency DEBOUNCE_CYCLES+2 edges from first pressed sample; no backpressure, pulses are fire-and-forget.
module button_pulse_conditioner #(
    parameter int NUM_BTN         = 3,
    parameter int DEBOUNCE_CYCLES = 1,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic                         clk,
    input  logic                         rst,
    button_pulse_conditioner_if.slave    bif
);
    localparam int                 CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]      CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [NUM_BTN-1:0] INV      = {NUM_BTN{ACTIVE_LOW}};

    logic [NUM_BTN-1:0] sync1;
    logic [NUM_BTN-1:0] sync2;
    logic [NUM_BTN-1:0] level;
    logic [NUM_BTN-1:0] level_nxt;
    logic [NUM_BTN-1:0] rise;
    logic [NUM_BTN-1:0] pulse;
    logic [NUM_BTN-1:0] pulse_nxt;
    logic               conflict;
    logic               conflict_nxt;
    logic [CW-1:0]      cnt     [NUM_BTN];
    logic [CW-1:0]      cnt_nxt [NUM_BTN];

    // Any sample that agrees with the accepted level restarts the run, so
    // bounces shorter than DEBOUNCE_CYCLES never reach the output.
    always_comb begin
        level_nxt = level;
        for (int i = 0; i < NUM_BTN; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != level[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    level_nxt[i] = ~level[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CW'(1);
                end
            end
        end
        rise         = level_nxt & ~level;
        pulse_nxt    = rise & (~rise + NUM_BTN'(1));
        conflict_nxt = |(rise & (rise - NUM_BTN'(1)));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1    <= '0;
            sync2    <= '0;
            level    <= '0;
            pulse    <= '0;
            conflict <= 1'b0;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1    <= bif.btn_raw ^ INV;
            sync2    <= sync1;
            level    <= level_nxt;
            pulse    <= pulse_nxt;
            conflict <= conflict_nxt;
            for (int i = 0; i < NUM_BTN; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
        end
    end

    assign bif.btn_level = level;
    assign bif.btn_pulse = pulse;
    assign bif.conflict  = conflict;
endmodule
